// File: rtl/adder_stream_ctrl.sv
// Handshaked sequencer around an external 3-bit adder: registers operand pairs,
// captures the 4-bit sum, and keeps a running accumulator with a sticky wrap flag.
module adder_stream_ctrl #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  output logic [2:0]       add_a,
  output logic [2:0]       add_b,
  input  logic [3:0]       add_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       add_a_q, add_a_d;
  logic [2:0]       add_b_q, add_b_d;
  logic [3:0]       out_sum_q, out_sum_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [ACC_W-1:0] acc_base;
  logic             ovf_base;
  logic [ACC_W:0]   acc_sum;

  // Result carries the wrap-out in its MSB.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] base,
                                             input logic [3:0]       inc);
    return {1'b0, base} + {{(ACC_W-3){1'b0}}, inc};
  endfunction

  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    // A clear in the accumulating cycle zeroes the base before the addition.
    acc_base    = clr ? '0 : acc_q;
    ovf_base    = clr ? 1'b0 : acc_ovf_q;
    acc_sum     = acc_add(acc_base, add_q);
    acc_d       = acc_base;
    acc_ovf_d   = ovf_base;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d = in_a;
          add_b_d = in_b;
          state_d = ADD;
        end
      end
      ADD: begin
        out_sum_d   = add_q;
        acc_d       = acc_sum[ACC_W-1:0];
        acc_ovf_d   = ovf_base | acc_sum[ACC_W];
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Directed bench for adder_stream_ctrl: two instances (ACC_W=8 and ACC_W=4)
// share stimulus, each wired to its own behavioural 3-bit adder.
module tb_adder_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr;
  logic [2:0] in_a, in_b;

  logic       in_ready8, out_valid8, acc_ovf8;
  logic [2:0] add_a8, add_b8;
  logic [3:0] add_q8, out_sum8;
  logic [7:0] acc8;

  logic       in_ready4, out_valid4, acc_ovf4;
  logic [2:0] add_a4, add_b4;
  logic [3:0] add_q4, out_sum4;
  logic [3:0] acc4;

  int checks = 0;
  int errors = 0;
  int m_acc8 = 0, m_acc4 = 0;
  logic m_ovf8 = 1'b0, m_ovf4 = 1'b0;

  always #5 clk = ~clk;

  assign add_q8 = {1'b0, add_a8} + {1'b0, add_b8};
  assign add_q4 = {1'b0, add_a4} + {1'b0, add_b4};

  adder_stream_ctrl u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .add_a(add_a8), .add_b(add_b8), .add_q(add_q8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .clr(clr), .acc(acc8), .acc_ovf(acc_ovf8)
  );

  adder_stream_ctrl #(.ACC_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .add_a(add_a4), .add_b(add_b4), .add_q(add_q4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_sum(out_sum4),
    .clr(clr), .acc(acc4), .acc_ovf(acc_ovf4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input int sum);
    m_acc8 = m_acc8 + sum;
    if (m_acc8 >= 256) begin m_acc8 -= 256; m_ovf8 = 1'b1; end
    m_acc4 = m_acc4 + sum;
    if (m_acc4 >= 16) begin m_acc4 -= 16; m_ovf4 = 1'b1; end
  endtask

  task automatic chk_acc(input string tag);
    chk({tag, "_acc8"}, 16'(acc8), 16'(m_acc8));
    chk({tag, "_ovf8"}, 16'(acc_ovf8), 16'(m_ovf8));
    chk({tag, "_acc4"}, 16'(acc4), 16'(m_acc4));
    chk({tag, "_ovf4"}, 16'(acc_ovf4), 16'(m_ovf4));
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_acc8 = 0; m_acc4 = 0; m_ovf8 = 1'b0; m_ovf4 = 1'b0;
    chk_acc(tag);
  endtask

  // Full transaction with out_ready held high: accept, ADD, HOLD handshake.
  task automatic do_pair(input logic [2:0] a, input logic [2:0] b, input string tag);
    int sum;
    sum = int'(a) + int'(b);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_add_a"}, 16'(add_a8), 16'(a));
    chk({tag, "_add_b"}, 16'(add_b8), 16'(b));
    chk({tag, "_rdy_add"}, 16'(in_ready8), 16'd0);
    chk({tag, "_vld_add"}, 16'(out_valid8), 16'd0);
    step();
    model_add(sum);
    chk({tag, "_vld_hold"}, 16'(out_valid8), 16'd1);
    chk({tag, "_sum8"}, 16'(out_sum8), 16'(sum));
    chk({tag, "_sum4"}, 16'(out_sum4), 16'(sum));
    chk_acc(tag);
    step();
    chk({tag, "_vld_idle"}, 16'(out_valid8), 16'd0);
    chk({tag, "_rdy_idle"}, 16'(in_ready8), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    in_a = 3'd0; in_b = 3'd0;
    #1;
    chk("rst_in_ready", 16'(in_ready8), 16'd1);
    step(); step();
    chk("rst_out_valid", 16'(out_valid8), 16'd0);
    chk("rst_add_a", 16'(add_a8), 16'd0);
    chk("rst_add_b", 16'(add_b8), 16'd0);
    chk_acc("rst");
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 16'(in_ready8), 16'd1);
    chk("idle_out_valid", 16'(out_valid8), 16'd0);

    // 6+7 = 13, single-cycle valid
    do_pair(3'd6, 3'd7, "p67");

    // Backpressure: 3+2 held for 5 stalled cycles, competing input ignored
    do_clr("clr_bp");
    in_valid = 1'b1; in_a = 3'd3; in_b = 3'd2; out_ready = 1'b0;
    step();
    in_a = 3'd7; in_b = 3'd7;
    step();
    model_add(5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 16'(out_valid8), 16'd1);
      chk("bp_sum", 16'(out_sum8), 16'd5);
      chk("bp_rdy", 16'(in_ready8), 16'd0);
      chk("bp_add_a", 16'(add_a8), 16'd3);
      chk_acc("bp");
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_vld", 16'(out_valid8), 16'd0);
    chk("bp_release_rdy", 16'(in_ready8), 16'd1);
    chk_acc("bp_once");

    // Wrap on the 4-bit accumulator: 13 then 20 mod 16 = 4
    do_clr("clr_wrap");
    do_pair(3'd7, 3'd6, "w76");
    do_pair(3'd4, 3'd3, "w43");
    chk("wrap_acc4", 16'(acc4), 16'd4);
    chk("wrap_ovf4", 16'(acc_ovf4), 16'd1);
    do_clr("clr_after_wrap");

    // Clear coincident with ADD: prior acc 9 (acc4 wrapped, ovf set) -> 10
    do_pair(3'd7, 3'd7, "c77");
    do_pair(3'd4, 3'd7, "c47");
    chk("pre_coinc_acc4", 16'(acc4), 16'd9);
    chk("pre_coinc_ovf4", 16'(acc_ovf4), 16'd1);
    in_valid = 1'b1; in_a = 3'd5; in_b = 3'd5; out_ready = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("coinc_acc8", 16'(acc8), 16'd10);
    chk("coinc_acc4", 16'(acc4), 16'd10);
    chk("coinc_ovf4", 16'(acc_ovf4), 16'd0);
    chk("coinc_sum", 16'(out_sum8), 16'd10);
    chk("coinc_vld", 16'(out_valid8), 16'd1);
    step();
    m_acc8 = 10; m_acc4 = 10; m_ovf8 = 1'b0; m_ovf4 = 1'b0;

    // Reset during ADD of 7+7 drops the pair
    in_valid = 1'b1; in_a = 3'd7; in_b = 3'd7;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_acc8 = 0; m_acc4 = 0;
    chk("rst_mid_vld", 16'(out_valid8), 16'd0);
    chk("rst_mid_sum", 16'(out_sum8), 16'd0);
    chk("rst_mid_rdy", 16'(in_ready8), 16'd1);
    chk("rst_mid_add_a", 16'(add_a8), 16'd0);
    chk_acc("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    chk_acc("rst_mid_after");
    do_pair(3'd1, 3'd1, "p11");
    chk("final_acc8", 16'(acc8), 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_stream_ctrl.md
# adder_stream_ctrl

Sequencing and accumulation stage that wraps the combinational 3-bit parallel adder (`parallel_adder_3bit`). It accepts operand pairs over a valid/ready handshake and registers them onto the adder inputs. It captures the 4-bit sum one cycle later, presents it downstream over a valid/ready handshake, and keeps a running accumulator of all sums with a sticky overflow flag. The adder is instantiated outside this block; this block drives its `a`/`b` and consumes its `q`.

## Interface
- `ACC_W`, default 8: accumulator width in bits; legal range 4..16.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair on `in_a`/`in_b` is valid.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`  in  3  operand A, unsigned.
- `in_b`  in  3  operand B, unsigned.
- `add_a`  out  3  registered operand A, drives adder `a`.
- `add_b`  out  3  registered operand B, drives adder `b`.
- `add_q`  in  4  adder result `q` (combinational from `add_a`/`add_b`).
- `out_valid`  out  1  `out_sum` holds a valid result.
- `out_ready`  in  1  downstream accepts `out_sum`.
- `out_sum`  out  4  registered sum, 0..14.
- `clr`  in  1  synchronous clear of `acc` and `acc_ovf`.
- `acc`  out  ACC_W  running total of accepted sums, modulo 2^ACC_W.
- `acc_ovf`  out  1  sticky flag; set when any accumulation wraps.

## Operation
- FSM states: IDLE, ADD, HOLD.
  - IDLE: `in_ready`=1. On `in_valid`, register `in_a`→`add_a` and `in_b`→`add_b`, then go to ADD.
  - ADD: `in_ready`=0. The adder settles. On this edge:
    - capture `add_q`→`out_sum`;
    - `acc` ← `acc` + zero-extended `add_q`;
    - set `out_valid`;
    - go to HOLD.
  - HOLD: `out_valid`=1, `in_ready`=0. On `out_valid`&`out_ready`, clear `out_valid` and go to IDLE.
- `in_ready` is decoded combinationally from state == IDLE.
- `add_a`, `add_b`, `out_sum` hold their values until next overwritten.
- Accumulation is unsigned:
  - the carry out of bit ACC_W-1 is discarded from `acc`;
  - that carry sets `acc_ovf`=1;
  - `acc_ovf` stays set until `clr` or reset.
- `clr`, any state: `acc` ← 0 and `acc_ovf` ← 0 on the next edge.
- `clr` in the same cycle as an ADD-state accumulation:
  - `acc` ← zero-extended `add_q`;
  - `acc_ovf` ← 0;
  - the clear applies first, then the addition.
- `clr` has no effect on the FSM, `out_sum`, or the handshakes.
- Reset (async assert, any state):
  - state ← IDLE;
  - `add_a`, `add_b`, `out_sum`, `acc` ← 0;
  - `out_valid`, `acc_ovf` ← 0;
  - hence `in_ready`=1 during and after reset.
- Reset asserted mid-transaction: the in-flight pair is dropped and nothing is accumulated.

## Timing
- Latency: input handshake at edge N → `out_valid`=1 and `acc` updated after edge N+1.
- Throughput: one result per 3 cycles when `out_ready` is held high; the block never pipelines a second pair.
- `in_valid` while not IDLE is ignored. The upstream holds data until `in_ready`; values are sampled only at the accepting edge.
- `out_valid` must not drop and `out_sum` must not change while stalled in HOLD.
- `add_q` is sampled only in ADD, one full cycle after `add_a`/`add_b` change.
- `rst_n` deassertion is synchronized externally; the first accepting edge is the first rising edge with `rst_n`=1.

## Test plan
- Reset then idle → `in_ready`=1, `out_valid`=0, `acc`=0, `acc_ovf`=0, `add_a`=`add_b`=0.
- Pair a=6, b=7, `out_ready`=1 → after 2 edges: `out_sum`=13, `acc`=13, `out_valid` high for 1 cycle, `in_ready` high again on the 3rd cycle.
- Backpressure: pair 3+2, `out_ready`=0 for 5 cycles → `out_sum`=5 and `out_valid` held. A new `in_valid` during the stall is ignored; `acc`=5 counted once.
- ACC_W=4: pairs 7+6 then 4+3 → `acc`=13 then 4 (20 mod 16), `acc_ovf`=1. Then `clr` → `acc`=0, `acc_ovf`=0.
- `clr` coincident with the ADD cycle of 5+5, prior `acc`=9 → `acc`=10, `acc_ovf`=0.
- `rst_n` low during ADD of 7+7 → `out_valid`=0, `acc`=0, `out_sum`=0, state IDLE. The next pair 1+1 yields `out_sum`=2, `acc`=2.
